eth_l2_header_frontend: RTL and testbench

Streaming Ethernet L2 header front end for the parser datapath; no AXI handshake logic of its own. It collects the first 18 bytes of a frame from 64-bit beats, extracts the destination MAC, source MAC and EtherType, and resolves a single 802.1Q tag. It classifies the payload protocol and publishes one registered `eth_metadata_t` record per frame, held until the next frame starts. It sits between the AXI-Stream ingress adapter, which supplies `beat_accept`, `frame_start` and `frame_end`, and downstream lookup/steering logic.

---
 rtl/eth_l2_header_frontend_if.sv | 51 +++++
 rtl/eth_l2_header_frontend.sv | 159 +++++++++++++++
 tb/tb_eth_l2_header_frontend.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/eth_l2_header_frontend_if.sv
// Stream-side bundle for eth_l2_header_frontend.
// Carries the frame framing pulses and beat data from the AXI-Stream ingress adapter
// and the per-frame metadata record back out to lookup/steering logic.
//   frame_start    : one-cycle pulse, new frame begins
//   frame_end      : one-cycle pulse, last accepted beat of the frame
//   beat_accept    : axis_tdata is consumed this cycle
//   axis_tdata     : 64-bit beat, byte k at bits [63-8k -: 8]
//   metadata       : registered eth_metadata_t record for the current frame
//   metadata_valid : metadata holds a result for the current frame
// Modports: master = ingress side (drives stream), slave = header front end.
interface eth_l2_header_frontend_if;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic        vlan_present;
    logic [11:0] vlan_id;
    logic [15:0] ethertype;
    logic [4:0]  l2_header_len;
    logic        is_ipv4;
    logic        is_ipv6;
    logic        is_arp;
    logic        is_unknown;
  } eth_metadata_t;

  logic          frame_start;
  logic          frame_end;
  logic          beat_accept;
  logic [63:0]   axis_tdata;
  eth_metadata_t metadata;
  logic          metadata_valid;

  modport master (
    output frame_start,
    output frame_end,
    output beat_accept,
    output axis_tdata,
    input  metadata,
    input  metadata_valid
  );

  modport slave (
    input  frame_start,
    input  frame_end,
    input  beat_accept,
    input  axis_tdata,
    output metadata,
    output metadata_valid
  );

endinterface

// File: rtl/eth_l2_header_frontend.sv
// Ethernet L2 header front end.
// Collects the first 18 header bytes from 64-bit beats, extracts DA/SA/EtherType,
// optionally resolves one 802.1Q tag, classifies the payload protocol and publishes one
// registered metadata record per frame, held until the next frame_start.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : eth_l2_header_frontend_if.slave (framing pulses, beat data, metadata out)
// Configuration macro: ETH_L2_VLAN_EN
//   defined   -> 802.1Q tag resolution, header complete after 3 beats
//   undefined -> no tag handling, header complete after 2 beats (14 bytes suffice)
module eth_l2_header_frontend (
  input  logic                     clk,
  input  logic                     rst_n,
  eth_l2_header_frontend_if.slave  bus
);

`ifdef ETH_L2_VLAN_EN
  localparam logic [1:0] LastHdrBeat = 2'd2;
`else
  localparam logic [1:0] LastHdrBeat = 2'd1;
`endif

  localparam logic [15:0] EtVlan = 16'h8100;
  localparam logic [15:0] EtIpv4 = 16'h0800;
  localparam logic [15:0] EtIpv6 = 16'h86DD;
  localparam logic [15:0] EtArp  = 16'h0806;

  // Header buffer, frame byte 0 in bits [143:136].
  logic [143:0] hdr_q, hdr_d;
  logic [1:0]   beat_cnt_q, beat_cnt_d;
  logic         header_valid_q, header_valid_d;
  // Frame ended before the header completed; capture whatever arrived.
  logic         trunc_q, trunc_d;
  logic [1:0]   beat_base;

  // Next-state for buffer, counter and status flags.
  always_comb begin
    hdr_d          = hdr_q;
    beat_cnt_d     = beat_cnt_q;
    header_valid_d = header_valid_q;
    trunc_d        = trunc_q;
    beat_base      = beat_cnt_q;

    if (bus.frame_start) begin
      hdr_d          = '0;
      beat_cnt_d     = 2'd0;
      header_valid_d = 1'b0;
      trunc_d        = 1'b0;
      beat_base      = 2'd0;
    end

    // A beat arriving with frame_start lands as beat 0 of the new frame.
    if (bus.beat_accept) begin
      unique case (beat_base)
        2'd0:    hdr_d[143:80] = bus.axis_tdata;
        2'd1:    hdr_d[79:16]  = bus.axis_tdata;
        2'd2:    hdr_d[15:0]   = bus.axis_tdata[63:48];
        default: ;
      endcase
      if (beat_base != 2'd3) begin
        beat_cnt_d = beat_base + 2'd1;
      end
      if (beat_base == LastHdrBeat) begin
        header_valid_d = 1'b1;
      end
    end

    // Looking at header_valid_d keeps a frame_end on the completing beat from being
    // mistaken for truncation.
    if (!bus.frame_start && bus.frame_end && !header_valid_d && !bus.metadata_valid) begin
      trunc_d = 1'b1;
    end
  end

  // Field extraction from the buffer.
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype_raw;
  logic        vlan_present;
  logic [11:0] vlan_id;
  logic [15:0] ethertype;
  logic [4:0]  l2_header_len;

  assign dest_mac      = hdr_q[143:96];
  assign src_mac       = hdr_q[95:48];
  assign ethertype_raw = hdr_q[47:32];

`ifdef ETH_L2_VLAN_EN
  always_comb begin
    if (ethertype_raw == EtVlan) begin
      vlan_present  = 1'b1;
      vlan_id       = {hdr_q[27:24], hdr_q[23:16]};
      ethertype     = hdr_q[15:0];
      l2_header_len = 5'd18;
    end else begin
      vlan_present  = 1'b0;
      vlan_id       = 12'h000;
      ethertype     = ethertype_raw;
      l2_header_len = 5'd14;
    end
  end
`else
  // Tag bytes are buffered but never consulted in this build.
  logic unused_tag_bytes;
  logic unused_vlan_et;
  assign unused_tag_bytes = ^hdr_q[31:0];
  assign unused_vlan_et   = ^EtVlan;
  assign vlan_present     = 1'b0;
  assign vlan_id          = 12'h000;
  assign ethertype        = ethertype_raw;
  assign l2_header_len    = 5'd14;
`endif

  // One-hot classification; a truncated header is always unknown.
  logic is_ipv4, is_ipv6, is_arp, is_unknown;
  always_comb begin
    is_ipv4    = header_valid_q && (ethertype == EtIpv4);
    is_ipv6    = header_valid_q && (ethertype == EtIpv6);
    is_arp     = header_valid_q && (ethertype == EtArp);
    is_unknown = !(is_ipv4 || is_ipv6 || is_arp);
  end

  logic capture;
  assign capture = !bus.metadata_valid && (header_valid_q || trunc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q              <= '0;
      beat_cnt_q         <= 2'd0;
      header_valid_q     <= 1'b0;
      trunc_q            <= 1'b0;
      bus.metadata       <= '0;
      bus.metadata_valid <= 1'b0;
    end else begin
      hdr_q          <= hdr_d;
      beat_cnt_q     <= beat_cnt_d;
      header_valid_q <= header_valid_d;
      trunc_q        <= trunc_d;
      if (bus.frame_start) begin
        bus.metadata       <= '0;
        bus.metadata_valid <= 1'b0;
      end else if (capture) begin
        bus.metadata.dest_mac      <= dest_mac;
        bus.metadata.src_mac       <= src_mac;
        bus.metadata.vlan_present  <= vlan_present;
        bus.metadata.vlan_id       <= vlan_id;
        bus.metadata.ethertype     <= ethertype;
        bus.metadata.l2_header_len <= l2_header_len;
        bus.metadata.is_ipv4       <= is_ipv4;
        bus.metadata.is_ipv6       <= is_ipv6;
        bus.metadata.is_arp        <= is_arp;
        bus.metadata.is_unknown    <= is_unknown;
        bus.metadata_valid         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_l2_header_frontend.sv
module tb_eth_l2_header_frontend;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eth_l2_header_frontend_if bus ();

  eth_l2_header_frontend dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef ETH_L2_VLAN_EN
  localparam int LatExp = 1;
`else
  localparam int LatExp = 0;
`endif

  localparam logic [63:0] B0 = 64'hFFFFFFFFFFFF0011;

  int checks = 0;
  int fails  = 0;
  int n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_meta(input string t, input logic [47:0] dest, input logic [47:0] src,
                          input logic [15:0] et, input logic vp, input logic [11:0] vid,
                          input logic [4:0] len, input logic [3:0] flags);
    chk({t, ".valid"}, 64'(bus.metadata_valid), 64'd1);
    chk({t, ".dest"}, 64'(bus.metadata.dest_mac), 64'(dest));
    chk({t, ".src"}, 64'(bus.metadata.src_mac), 64'(src));
    chk({t, ".et"}, 64'(bus.metadata.ethertype), 64'(et));
    chk({t, ".vlan"}, 64'({bus.metadata.vlan_present, bus.metadata.vlan_id}), 64'({vp, vid}));
    chk({t, ".len"}, 64'(bus.metadata.l2_header_len), 64'(len));
    chk({t, ".flags"}, 64'({bus.metadata.is_ipv4, bus.metadata.is_ipv6, bus.metadata.is_arp,
                            bus.metadata.is_unknown}), 64'(flags));
  endtask

  task automatic start();
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic fe);
    bus.beat_accept = 1'b1;
    bus.axis_tdata  = d;
    bus.frame_end   = fe;
    @(posedge clk); #1;
    bus.beat_accept = 1'b0;
    bus.frame_end   = 1'b0;
    bus.axis_tdata  = '0;
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Bounded wait; returns the number of edges needed.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (bus.metadata_valid !== 1'b1 && cnt < 6) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.beat_accept = 1'b0;
    bus.axis_tdata  = '0;
    idle(2);
    chk("rst.valid", 64'(bus.metadata_valid), 64'd0);
    chk("rst.meta", 64'(|bus.metadata), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // IPv4 untagged, then extra beats that must not disturb the record.
    start();
    beat(B0, 1'b0);
    beat(64'h2233445508000000, 1'b0);
    beat(64'h0, 1'b1);
    wait_valid(n);
    chk("ipv4.latency", 64'(n), 64'(LatExp));
    chk_meta("ipv4", 48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 1'b0, 12'h0, 5'd14, 4'b1000);
    beat(64'hAAAAAAAAAAAAAAAA, 1'b0);
    beat(64'h5555555555555555, 1'b1);
    idle(2);
    chk_meta("extra", 48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 1'b0, 12'h0, 5'd14, 4'b1000);

    // 802.1Q tagged IPv6.
    start();
    chk("vlan.cleared", 64'(bus.metadata_valid), 64'd0);
    beat(B0, 1'b0);
    beat(64'h2233445581000064, 1'b0);
    beat(64'h86DD000000000000, 1'b1);
    wait_valid(n);
`ifdef ETH_L2_VLAN_EN
    chk_meta("vlan", 48'hFFFFFFFFFFFF, 48'h001122334455, 16'h86DD, 1'b1, 12'h064, 5'd18,
             4'b0100);
`else
    chk_meta("vlan", 48'hFFFFFFFFFFFF, 48'h001122334455, 16'h8100, 1'b0, 12'h000, 5'd14,
             4'b0001);
`endif

    // ARP then unknown back-to-back.
    start();
    chk("arp.cleared", 64'(bus.metadata_valid), 64'd0);
    chk("arp.dest_cleared", 64'(bus.metadata.dest_mac), 64'd0);
    beat(B0, 1'b0);
    beat(64'h2233445508060000, 1'b0);
    beat(64'h0, 1'b1);
    wait_valid(n);
    chk_meta("arp", 48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0806, 1'b0, 12'h0, 5'd14, 4'b0010);
    start();
    chk("unk.cleared", 64'(bus.metadata_valid), 64'd0);
    beat(B0, 1'b0);
    beat(64'h2233445588CC0000, 1'b0);
    beat(64'h0, 1'b1);
    wait_valid(n);
    chk_meta("unk", 48'hFFFFFFFFFFFF, 48'h001122334455, 16'h88CC, 1'b0, 12'h0, 5'd14, 4'b0001);

    // Truncated frame: single beat carrying frame_end.
    start();
    beat(64'h0102030405060708, 1'b1);
    chk("trunc.early", 64'(bus.metadata_valid), 64'd0);
    wait_valid(n);
    chk("trunc.latency", 64'(n), 64'd1);
    chk_meta("trunc", 48'h010203040506, 48'h070800000000, 16'h0000, 1'b0, 12'h0, 5'd14, 4'b0001);
    idle(3);
    chk("trunc.hold", 64'(bus.metadata_valid), 64'd1);

    // Reset mid-frame, then a frame whose first beat shares the frame_start cycle.
    start();
    beat(B0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst.valid", 64'(bus.metadata_valid), 64'd0);
    chk("midrst.meta", 64'(|bus.metadata), 64'd0);
    idle(1);
    rst_n = 1'b1;
    idle(4);
    chk("midrst.none", 64'(bus.metadata_valid), 64'd0);
    bus.frame_start = 1'b1;
    beat(B0, 1'b0);
    bus.frame_start = 1'b0;
    beat(64'h2233445508000000, 1'b0);
    beat(64'h0, 1'b1);
    wait_valid(n);
    chk_meta("post_rst", 48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 1'b0, 12'h0, 5'd14,
             4'b1000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
